// File: rtl/rf_sb_pkg.sv
// Shared sizing and types for the register-file scoreboard.
package rf_sb_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: saturating up/down with synchronous flush.
module sb_counter
    import rf_sb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    dec,
    input  logic    flush,
    output sb_cnt_t cnt,
    output logic    is_zero,
    output logic    is_max
);

    localparam sb_cnt_t MaxVal = sb_cnt_t'(CNT_MAX);

    sb_cnt_t cnt_q;
    sb_cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && dec) begin
            cnt_d = cnt_q;
        end else if (inc && cnt_q != MaxVal) begin
            cnt_d = cnt_q + sb_cnt_t'(1);
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - sb_cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign is_zero = (cnt_q == '0);
    assign is_max  = (cnt_q == MaxVal);

`ifndef SYNTHESIS
    // A retire with nothing pending means WB and ID disagree about what is in flight.
    assert property (@(posedge clk) disable iff (rst) (dec && !flush) |-> (cnt_q != '0))
        else $error("sb_counter: retire of a register with no pending write");
`endif

endmodule

// File: rtl/rf_scoreboard.sv
// RAW / write-count hazard scoreboard for the ID stage.
// Define SB_WB_BYPASS_EN to let a source whose last pending write retires this cycle proceed.
module rf_scoreboard
    import rf_sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    input  logic      issue_fire,
    input  logic      issue_rf_we,
    input  reg_addr_t issue_rf_waddr,
    input  logic      src1_re,
    input  reg_addr_t src1_addr,
    input  logic      src2_re,
    input  reg_addr_t src2_addr,
    input  logic      retire_fire,
    input  reg_addr_t retire_rf_waddr,
    input  logic      flush,
    output logic      stall,
    output logic      sb_empty
);

    sb_cnt_t             cnt [NUM_REGS];
    logic [NUM_REGS-1:0] is_zero;
    logic [NUM_REGS-1:0] is_max;

    logic inc;
    logic dec;
    logic haz1;
    logic haz2;
    logic byp1;
    logic byp2;
    logic sat;

    // r0 is hard-wired: never pending, never saturated.
    assign cnt[0]     = '0;
    assign is_zero[0] = 1'b1;
    assign is_max[0]  = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc && (issue_rf_waddr == reg_addr_t'(i))),
            .dec     (dec && (retire_rf_waddr == reg_addr_t'(i))),
            .flush   (flush),
            .cnt     (cnt[i]),
            .is_zero (is_zero[i]),
            .is_max  (is_max[i])
        );
    end

    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
`ifdef SB_WB_BYPASS_EN
        byp1 = retire_fire && (retire_rf_waddr == src1_addr) && (cnt[src1_addr] == sb_cnt_t'(1));
        byp2 = retire_fire && (retire_rf_waddr == src2_addr) && (cnt[src2_addr] == sb_cnt_t'(1));
`endif
        haz1  = src1_re && (src1_addr != '0) && (cnt[src1_addr] != '0) && !byp1;
        haz2  = src2_re && (src2_addr != '0) && (cnt[src2_addr] != '0) && !byp2;
        sat   = issue_rf_we && (issue_rf_waddr != '0) && is_max[issue_rf_waddr];
        stall = issue_valid && (haz1 || haz2 || sat);
        // A fire during stall is a protocol violation; gating it keeps the counts honest.
        inc   = issue_fire && !stall && issue_rf_we && (issue_rf_waddr != '0);
        dec   = retire_fire && (retire_rf_waddr != '0);
    end

    assign sb_empty = &is_zero;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed scenarios plus random traffic against a per-register count model.
module tb_rf_scoreboard;
    import rf_sb_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      issue_valid;
    logic      issue_fire;
    logic      issue_rf_we;
    reg_addr_t issue_rf_waddr;
    logic      src1_re;
    reg_addr_t src1_addr;
    logic      src2_re;
    reg_addr_t src2_addr;
    logic      retire_fire;
    reg_addr_t retire_rf_waddr;
    logic      flush;
    logic      stall;
    logic      sb_empty;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned m_cnt [NUM_REGS];

    rf_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_fire      (issue_fire),
        .issue_rf_we     (issue_rf_we),
        .issue_rf_waddr  (issue_rf_waddr),
        .src1_re         (src1_re),
        .src1_addr       (src1_addr),
        .src2_re         (src2_re),
        .src2_addr       (src2_addr),
        .retire_fire     (retire_fire),
        .retire_rf_waddr (retire_rf_waddr),
        .flush           (flush),
        .stall           (stall),
        .sb_empty        (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst             = 1'b0;
        issue_valid     = 1'b0;
        issue_fire      = 1'b0;
        issue_rf_we     = 1'b0;
        issue_rf_waddr  = '0;
        src1_re         = 1'b0;
        src1_addr       = '0;
        src2_re         = 1'b0;
        src2_addr       = '0;
        retire_fire     = 1'b0;
        retire_rf_waddr = '0;
        flush           = 1'b0;
    endtask

    function automatic bit model_stall();
        bit h1;
        bit h2;
        bit sat;
        h1 = src1_re && src1_addr != 0 && m_cnt[src1_addr] != 0;
        h2 = src2_re && src2_addr != 0 && m_cnt[src2_addr] != 0;
`ifdef SB_WB_BYPASS_EN
        if (retire_fire && retire_rf_waddr == src1_addr && m_cnt[src1_addr] == 1) h1 = 1'b0;
        if (retire_fire && retire_rf_waddr == src2_addr && m_cnt[src2_addr] == 1) h2 = 1'b0;
`endif
        sat = issue_rf_we && issue_rf_waddr != 0 && m_cnt[issue_rf_waddr] == CNT_MAX;
        return issue_valid && (h1 || h2 || sat);
    endfunction

    // Inputs are already driven (at the falling edge); check, then advance one clock.
    task automatic step(input string tag);
        bit          exp_stall;
        bit          exp_empty;
        bit          do_inc;
        bit          do_dec;
        int unsigned nxt [NUM_REGS];
        #1;
        exp_stall = model_stall();
        exp_empty = 1'b1;
        foreach (m_cnt[i]) if (m_cnt[i] != 0) exp_empty = 1'b0;
        check({tag, ".stall"}, stall, exp_stall);
        check({tag, ".empty"}, sb_empty, exp_empty);
        nxt    = m_cnt;
        do_inc = issue_fire && !exp_stall && issue_rf_we && issue_rf_waddr != 0;
        do_dec = retire_fire && retire_rf_waddr != 0;
        if (rst || flush) begin
            foreach (nxt[i]) nxt[i] = 0;
        end else if (!(do_inc && do_dec && issue_rf_waddr == retire_rf_waddr)) begin
            if (do_inc && nxt[issue_rf_waddr] < CNT_MAX) nxt[issue_rf_waddr]++;
            if (do_dec && nxt[retire_rf_waddr] > 0) nxt[retire_rf_waddr]--;
        end
        @(posedge clk);
        m_cnt = nxt;
        @(negedge clk);
    endtask

    task automatic issue_wr(input int unsigned rd);
        idle();
        issue_valid    = 1'b1;
        issue_fire     = 1'b1;
        issue_rf_we    = 1'b1;
        issue_rf_waddr = reg_addr_t'(rd);
    endtask

    task automatic reader(input int unsigned rs);
        idle();
        issue_valid = 1'b1;
        src1_re     = 1'b1;
        src1_addr   = reg_addr_t'(rs);
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        step("reset");

        // RAW on r4: three stall cycles, retire at the third
        issue_wr(4);                       step("raw.issue");
        reader(4);                         step("raw.c1");
        reader(4);                         step("raw.c2");
        reader(4); retire_fire = 1'b1; retire_rf_waddr = 5'd4; step("raw.c3");
        reader(4);                         step("raw.c4");

        // Saturation on r7
        repeat (3) begin issue_wr(7);      step("sat.fill"); end
        issue_wr(7); issue_fire = 1'b0;    step("sat.full");
        issue_wr(7); issue_fire = 1'b0; retire_fire = 1'b1; retire_rf_waddr = 5'd7;
        step("sat.retire");
        issue_wr(7);                       step("sat.go");
        reader(7);                         step("sat.rd");

        // Same-register issue and retire on r5
        issue_wr(5);                       step("same.fill");
        issue_wr(5); retire_fire = 1'b1; retire_rf_waddr = 5'd5; step("same.both");
        reader(5);                         step("same.rd");
        idle(); retire_fire = 1'b1; retire_rf_waddr = 5'd5; step("same.drain");
        reader(5);                         step("same.clear");

        // r0 is invisible; then reset clears everything pending
        idle(); rst = 1'b1;                step("rst.a");
        issue_wr(0); src1_re = 1'b1;       step("r0.wr");
        issue_wr(0); src1_re = 1'b1;       step("r0.wr2");
        idle();                            step("r0.empty");

        // Flush beats a concurrent retire
        issue_wr(2);                       step("fl.r2");
        issue_wr(3);                       step("fl.r3");
        issue_wr(9);                       step("fl.r9");
        idle(); flush = 1'b1; retire_fire = 1'b1; retire_rf_waddr = 5'd2; step("fl.go");
        reader(2);                         step("fl.after");

        // Fire during stall is gated: r8 must not become pending
        issue_wr(6);                       step("gate.r6");
        issue_wr(8); src1_re = 1'b1; src1_addr = 5'd6; step("gate.fire");
        reader(8);                         step("gate.r8");
        idle(); rst = 1'b1;                step("gate.rst");
        idle();                            step("gate.empty");

        // Random traffic over a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            idle();
            issue_valid    = 1'($urandom_range(0, 1));
            issue_fire     = issue_valid && ($urandom_range(0, 3) != 0);
            issue_rf_we    = ($urandom_range(0, 3) != 0);
            issue_rf_waddr = reg_addr_t'($urandom_range(0, 7));
            src1_re        = 1'($urandom_range(0, 1));
            src1_addr      = reg_addr_t'($urandom_range(0, 7));
            src2_re        = 1'($urandom_range(0, 1));
            src2_addr      = reg_addr_t'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1 && (r == 0 || m_cnt[r] != 0)) begin
                retire_fire     = 1'b1;
                retire_rf_waddr = reg_addr_t'(r);
            end
            flush = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
